// File: rtl/wht_pkg.sv
// Shared constants for the 4x4 Walsh-Hadamard engine: mode encodings, lane count,
// scaling constants and the internal column-pass width helper.
package wht_pkg;

  localparam logic WHT_FWD = 1'b0;
  localparam logic WHT_INV = 1'b1;

  localparam int WHT_LANES   = 16;
  localparam int WHT_INV_RND = 3;
  localparam int WHT_INV_SH  = 3;
  localparam int WHT_FWD_SH  = 1;

  // Two butterfly passes add 4 bits of growth; one more absorbs the inverse rounding add.
  function automatic int wht_int_w(input int data_w);
    return data_w + 5;
  endfunction

endpackage

// File: rtl/wht4_butterfly.sv
// Combinational 4-point Walsh-Hadamard butterfly; output is 2 bits wider than input
// so no pass ever overflows.
module wht4_butterfly
  import wht_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [3:0][W-1:0] x,
  output logic [3:0][W+1:0] y
);

  logic signed [W+1:0] e0, e1, e2, e3;
  logic signed [W+1:0] a0, a1, a2, a3;

  always_comb begin
    e0 = {{2{x[0][W-1]}}, x[0]};
    e1 = {{2{x[1][W-1]}}, x[1]};
    e2 = {{2{x[2][W-1]}}, x[2]};
    e3 = {{2{x[3][W-1]}}, x[3]};
    a0 = e0 + e2;
    a1 = e1 + e3;
    a2 = e1 - e3;
    a3 = e0 - e2;
    y[0] = a0 + a1;
    y[1] = a3 + a2;
    y[2] = a3 - a2;
    y[3] = a0 - a1;
  end

endmodule

// File: rtl/wht4x4_pipe.sv
// Streaming 4x4 WHT (forward >>>1 / inverse (x+3)>>>3), row pass then column pass,
// 2-stage valid/ready pipeline. Define WHT_SAT_EN to clamp outputs instead of wrapping.
module wht4x4_pipe
  import wht_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [WHT_LANES*DATA_W-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WHT_LANES*OUT_W-1:0]    out_data,
  output logic                          out_mode,
  output logic                          out_sat,
  output logic                          busy
);

  localparam int W1 = DATA_W + 2;
  localparam int W2 = DATA_W + 4;
  localparam int IW = wht_int_w(DATA_W);

  function automatic logic signed [IW-1:0] scale(input logic signed [IW-1:0] s, input logic inv);
    if (inv == WHT_INV) return (s + IW'(WHT_INV_RND)) >>> WHT_INV_SH;
    else                return s >>> WHT_FWD_SH;
  endfunction

  // [1] = row-pass stage holds a block, [2] = output stage holds a block
  logic [2:1] vld_pipe_d, vld_pipe_q;
  logic       s2_ready, in_fire, s1_adv;

  assign s2_ready  = !vld_pipe_q[2] || out_ready;
  assign in_ready  = !vld_pipe_q[1] || s2_ready;
  assign in_fire   = in_valid && in_ready;
  assign s1_adv    = vld_pipe_q[1] && s2_ready;
  assign out_valid = vld_pipe_q[2];
  assign busy      = |vld_pipe_q;

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    if (in_fire)        vld_pipe_d[1] = 1'b1;
    else if (s1_adv)    vld_pipe_d[1] = 1'b0;
    if (s1_adv)         vld_pipe_d[2] = 1'b1;
    else if (out_ready) vld_pipe_d[2] = 1'b0;
  end

  // Row pass
  logic [WHT_LANES-1:0][DATA_W-1:0] x;
  logic [WHT_LANES-1:0][W1-1:0]     t_row, t_d, t_q;
  logic                             mode1_d, mode1_q;

  assign x = in_data;

  for (genvar r = 0; r < 4; r++) begin : g_row
    wht4_butterfly #(.W(DATA_W)) u_bfly (.x(x[4*r+3 -: 4]), .y(t_row[4*r+3 -: 4]));
  end

  // Column pass, scale and width reduction; output row r / column c lands in lane 4r+c
  logic [3:0][3:0][W1-1:0]         col_x;
  logic [3:0][3:0][W2-1:0]         col_y;
  logic [WHT_LANES-1:0][OUT_W-1:0] y_lane, out_data_d, out_data_q;
  logic [WHT_LANES-1:0]            sat_lane;
  logic                            out_mode_d, out_mode_q;

  for (genvar c = 0; c < 4; c++) begin : g_col
    assign col_x[c] = {t_q[12+c], t_q[8+c], t_q[4+c], t_q[c]};
    wht4_butterfly #(.W(W1)) u_bfly (.x(col_x[c]), .y(col_y[c]));

    for (genvar r = 0; r < 4; r++) begin : g_lane
      logic signed [IW-1:0] s;
      logic [OUT_W-1:0]     y;
      logic                 sat;

      assign s = {{(IW-W2){col_y[c][r][W2-1]}}, col_y[c][r]};

`ifdef WHT_SAT_EN
      localparam logic signed [IW-1:0] HI = {{(IW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
      localparam logic signed [IW-1:0] LO = {{(IW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
      logic signed [IW-1:0] sc;

      assign sc = scale(s, mode1_q);

      always_comb begin
        y   = sc[OUT_W-1:0];
        sat = 1'b0;
        if (sc > HI) begin
          y   = HI[OUT_W-1:0];
          sat = 1'b1;
        end else if (sc < LO) begin
          y   = LO[OUT_W-1:0];
          sat = 1'b1;
        end
      end
`else
      assign y   = OUT_W'(scale(s, mode1_q));
      assign sat = 1'b0;
`endif

      assign y_lane[4*r+c]   = y;
      assign sat_lane[4*r+c] = sat;
    end
  end

  always_comb begin
    t_d        = in_fire ? t_row   : t_q;
    mode1_d    = in_fire ? in_mode : mode1_q;
    out_data_d = s1_adv  ? y_lane  : out_data_q;
    out_mode_d = s1_adv  ? mode1_q : out_mode_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      t_q        <= '0;
      mode1_q    <= 1'b0;
      out_data_q <= '0;
      out_mode_q <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      t_q        <= t_d;
      mode1_q    <= mode1_d;
      out_data_q <= out_data_d;
      out_mode_q <= out_mode_d;
    end
  end

  assign out_data = out_data_q;
  assign out_mode = out_mode_q;

`ifdef WHT_SAT_EN
  logic out_sat_d, out_sat_q;

  always_comb out_sat_d = s1_adv ? |sat_lane : out_sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_sat_q <= 1'b0;
    else        out_sat_q <= out_sat_d;
  end

  assign out_sat = out_sat_q;
`else
  logic unused_sat;
  assign unused_sat = |sat_lane;
  assign out_sat    = 1'b0;
`endif

endmodule

// File: tb/tb_wht4x4_pipe.sv
// Scoreboard bench for wht4x4_pipe: directed blocks push hand-derived results,
// a negedge monitor pops and compares on every output transfer.
module tb_wht4x4_pipe;

  localparam int DW = 16;
  localparam int OW = 12;

  typedef logic [15:0][DW-1:0] ilanes_t;
  typedef logic [15:0][OW-1:0] olanes_t;
  typedef struct packed {
    olanes_t data;
    logic    mode;
    logic    sat;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_mode = 1'b0;
  logic [16*DW-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [16*OW-1:0] out_data;
  logic            out_mode;
  logic            out_sat;
  logic            busy;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  wht4x4_pipe #(.DATA_W(DW), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic ilanes_t i_all(input int v);
    ilanes_t r;
    for (int k = 0; k < 16; k++) r[k] = DW'(v);
    return r;
  endfunction

  function automatic ilanes_t i_one(input int lane, input int v);
    ilanes_t r = '0;
    r[lane] = DW'(v);
    return r;
  endfunction

  function automatic olanes_t o_all(input int v);
    olanes_t r;
    for (int k = 0; k < 16; k++) r[k] = OW'(v);
    return r;
  endfunction

  function automatic olanes_t o_one(input int lane, input int v);
    olanes_t r = '0;
    r[lane] = OW'(v);
    return r;
  endfunction

  // columns 0,1 take a; columns 2,3 take b
  function automatic olanes_t o_cols(input int a, input int b);
    olanes_t r;
    for (int k = 0; k < 16; k++) r[k] = ((k % 4) < 2) ? OW'(a) : OW'(b);
    return r;
  endfunction

  task automatic send(input ilanes_t d, input logic m, input olanes_t ed, input logic es,
                      output int tries);
    logic got = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    tries    = 0;
    while (!got && tries < 40) begin
      @(negedge clk);
      tries++;
      got = in_ready;
      if (got) begin
        e.data = ed; e.mode = m; e.sat = es;
        sb.push_back(e);
      end
      @(posedge clk); #1;
    end
    if (!got) chk("send_timeout", 256'(tries), 256'(0));
  endtask

  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) chk("drain_timeout", 256'(sb.size()), 256'(0));
    @(posedge clk); #1;
  endtask

  // Monitor: compares every output transfer and checks hold-stability under stall
  initial begin
    logic    prev_stall = 1'b0;
    olanes_t prev_d = '0;
    logic    prev_m = 1'b0;
    exp_t    e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_data", out_data, prev_d);
          chk("stall_mode", out_mode, prev_m);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output act=%0h exp=none", out_data);
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_mode", out_mode, e.mode);
            chk("out_sat",  out_sat,  e.sat);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        prev_m     = out_mode;
      end
    end
  end

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_mode",  out_mode,  0);
    chk("rst_out_sat",   out_sat,   0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Forward DC plus latency
    send(i_all(1), 1'b0, o_one(0, 8), 1'b0, t);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_out_valid", out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_cycle2_out_valid", out_valid, 1);
    drain();

    // Inverse DC, then forward floor shift of a negative value
    send(i_one(0, 8),  1'b1, o_all(1),  1'b0, t);
    send(i_one(0, -3), 1'b0, o_all(-2), 1'b0, t);
    drain();

    // Backpressure: output held off for 3 cycles after first out_valid
    out_ready = 1'b0;
    fork
      begin
        int t1;
        send(i_all(1),       1'b0, o_one(0, 8),   1'b0, t1);
        send(i_one(0, 20),   1'b1, o_all(2),      1'b0, t1);
        send(i_all(-2),      1'b0, o_one(0, -16), 1'b0, t1);
        send(i_one(0, -20),  1'b1, o_all(-3),     1'b0, t1);
        in_valid = 1'b0;
      end
      begin
        int n = 0;
        while (!out_valid && n < 30) begin
          @(negedge clk);
          n++;
        end
        chk("bp_first_out_valid", out_valid, 1);
        chk("bp_in_ready_low", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Alternating modes at full rate
    fork
      begin
        int t2;
        send(i_one(1, 10),  1'b0, o_cols(5, -5), 1'b0, t2);
        chk("rate_accept0", t2, 1);
        send(i_one(1, 10),  1'b1, o_cols(1, -1), 1'b0, t2);
        chk("rate_accept1", t2, 1);
        send(i_one(1, -6),  1'b0, o_cols(-3, 3), 1'b0, t2);
        chk("rate_accept2", t2, 1);
        send(i_one(1, -16), 1'b1, o_cols(-2, 2), 1'b0, t2);
        chk("rate_accept3", t2, 1);
        in_valid = 1'b0;
      end
      begin
        int n = 0;
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        chk("rate_first_out_valid", out_valid, 1);
        repeat (3) begin
          @(negedge clk);
          chk("rate_out_valid", out_valid, 1);
        end
      end
    join
    drain();

    // Saturation boundary
`ifdef WHT_SAT_EN
    send(i_all(2047), 1'b0, o_one(0, 2047), 1'b1, t);
`else
    send(i_all(2047), 1'b0, o_one(0, -8), 1'b0, t);
`endif
    drain();

    // Reset with two blocks in flight
    out_ready = 1'b0;
    send(i_all(3),     1'b0, o_one(0, 24), 1'b0, t);
    send(i_one(0, 16), 1'b1, o_all(2),     1'b0, t);
    in_valid = 1'b0;
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_in_ready", in_ready, 1);
    repeat (5) @(negedge clk);
    chk("post_reset_no_stale", out_valid, 0);
    @(posedge clk); #1;
    send(i_one(0, 8), 1'b1, o_all(1), 1'b0, t);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wht4x4_pipe.md
Name: wht4x4_pipe

Overview:
- Parametrised, streaming 4x4 Walsh-Hadamard transform engine for the VP8 luma-DC path.
- Supports forward (encoder, result >>>1) and inverse (reconstruction, (x+3)>>>3) per block through a shared separable datapath.
- 2-stage registered pipeline with valid/ready handshake at both ends. Sustains one block per cycle and stalls cleanly under backpressure.
- Sits between the DC-gather stage and quantiser (forward), and between dequantiser and per-block IDCT (inverse).

Parameters:
- DATA_W, 16, signed width of each input coefficient (lanes packed at 16*DATA_W bits).
- OUT_W, 16, signed width of each output coefficient (must satisfy 8 <= OUT_W <= DATA_W+4).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_valid  in  1  input block valid
- in_ready  out  1  engine can accept a block this cycle
- in_mode  in  1  0 = forward, 1 = inverse; sampled with the block
- in_data  in  16*DATA_W  raster-order coefficients; lane k at bits [DATA_W*(k+1)-1 : DATA_W*k]
- out_valid  out  1  output block valid
- out_ready  in  1  downstream accepts
- out_data  out  16*OUT_W  raster-order results, same packing with OUT_W
- out_mode  out  1  mode that travelled with the block
- out_sat  out  1  any lane clamped (tied 0 without WHT_SAT_EN)
- busy  out  1  s1_valid | s2_valid

Interface note:
- One clock, clk.
- Reset rst_n is asynchronous, active-low.

Behaviour:
- Reset values: all pipeline registers, out_data, out_mode, out_sat, out_valid and busy are 0. in_ready is 1 as soon as reset deasserts.
- Transfer rules:
  - A transfer occurs when valid and ready are both high in the same cycle.
  - in_ready = !s1_valid | s2_ready.
  - s2_ready = !out_valid | out_ready.
  - No combinational path from in_valid to in_ready.
- Stage 1 (row pass, registered on input transfer):
  - Per row r: a0=x0+x2, a1=x1+x3, a2=x1-x3, a3=x0-x2.
  - t0=a0+a1, t1=a3+a2, t2=a3-a2, t3=a0-a1.
  - Width DATA_W+2, sign-extended. Mode is registered alongside.
- Stage 2 (column pass + scale, registered when s1_valid & s2_ready):
  - Per column c: b0=t[c]+t[8+c], b1=t[4+c]+t[12+c], b2=t[4+c]-t[12+c], b3=t[c]-t[8+c].
  - Outputs: row0 = b0+b1, row1 = b3+b2, row2 = b3-b2, row3 = b0-b1.
  - Internal width DATA_W+5; no intermediate truncation.
  - Scale: forward y = s>>>1; inverse y = (s+3)>>>3 (arithmetic shift, floor).
  - Result reduced to OUT_W per the optional feature.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput 1 block/cycle.
- Stall: while out_valid & !out_ready, out_* hold stable and stage 2 does not load. Stage 1 holds once full, and in_ready drops. At most 2 blocks are in flight.
- Simultaneous events:
  - Output transfer and stage-1 advance in the same cycle are allowed (no bubble).
  - Input accept into a stage 1 that is draining the same cycle is allowed.
- Mode may change on every block; each block uses its own registered mode.
- Reset mid-operation: in-flight blocks are discarded, all valids clear immediately, and no partial output appears.
- Data registers load only on advance; valid registers are the only state that affects the handshake.

Optional Feature:
- Macro WHT_SAT_EN.
- Defined: each lane clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. out_sat = OR of per-lane clamp flags, registered with the data.
- Undefined: each lane takes the low OUT_W bits (two's-complement wrap) and out_sat is constant 0.

Decomposition:
- Package wht_pkg:
  - WHT_FWD=1'b0, WHT_INV=1'b1.
  - Lane count WHT_LANES=16.
  - Rounding constants WHT_INV_RND=3, WHT_INV_SH=3, WHT_FWD_SH=1.
  - Width helper function for internal width (DATA_W+5).
- Sub-module wht4_butterfly: combinational 4-point butterfly, parametrised width, instantiated 4x per pass.
- Stage control, scaling and saturation stay in wht4x4_pipe.

Test Plan:
- Forward DC: all 16 lanes = 1, mode 0 -> out lane0 = 8, lanes 1..15 = 0, out_valid exactly 2 cycles after accept.
- Inverse DC: lane0 = 8, others 0, mode 1 -> all 16 lanes = 1. Then lane0 = -3, mode 0 -> all lanes = -2 (floor shift).
- Backpressure: 4 back-to-back blocks with out_ready low for 3 cycles after the first out_valid.
  - in_ready falls after 2 blocks are held; out_data is stable while stalled.
  - All 4 blocks emerge in order, unduplicated, with correct out_mode.
- Alternating modes 0/1/0/1 at full rate with out_ready=1 -> one result per cycle, each scaled per its own mode.
- Saturation, DATA_W=16, OUT_W=12, all lanes 2047, mode 0:
  - With WHT_SAT_EN: lane0 = 2047, out_sat = 1.
  - Without: lane0 = -8, out_sat = 0.
- Reset: assert rst_n low while 2 blocks are in flight -> out_valid and busy are 0 immediately, in_ready = 1 after release, and no stale block is emitted.
